// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// Opcode/funct values match those used by the combinational decode controller.
package multicycle_sequencer_pkg;

  localparam int unsigned SeqStateWidth  = 3;
  localparam int unsigned DefaultTimeout = 255;

  typedef enum logic [SeqStateWidth-1:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } seq_state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLw,
    ClsSw,
    ClsBranch,
    ClsJr,
    ClsJ,
    ClsJal,
    ClsIllegal
  } instr_class_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnJr    = 6'b001000;

  function automatic instr_class_e decode_class(input logic [5:0] opcode,
                                                input logic [5:0] func);
    instr_class_e cls;
    cls = ClsIllegal;
    casez (opcode)
      OpRtype:      cls = (func == FnJr) ? ClsJr : ClsAlu;
      // addi, addiu, slti, sltiu, andi, ori, xori, lui
      6'b001???:    cls = ClsAlu;
      OpLw:         cls = ClsLw;
      OpSw:         cls = ClsSw;
      OpBeq, OpBne: cls = ClsBranch;
      OpJ:          cls = ClsJ;
      OpJal:        cls = ClsJal;
      default:      cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags that the count has reached TIMEOUT.
module mem_wait_timer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [7:0] Limit = 8'(TIMEOUT);

  logic [7:0] count_q, count_d;

  assign expired = (count_q == Limit);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (count && !expired) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control sequencer: steps IF/ID/EX/MEM/WB, stalls on memory,
// and parks in HALT on request or on a bus timeout.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        ir_load,
  output logic        alu_en,
  output logic        dmem_rd_req,
  output logic        dmem_wr_req,
  output logic        reg_wr_en,
  output logic        pc_en,
  output logic [SeqStateWidth-1:0] state,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal,
  output logic [31:0] retired
);

  seq_state_e   state_q, state_d;
  instr_class_e class_q, id_class, cur_class;
  logic         bus_err_q, bus_err_d;
  logic [31:0]  retired_q;

  logic in_wait, wait_expired, timeout, retire;
  logic imem_c, ir_load_c, alu_c, rd_c, wr_c, reg_wr_c, illegal_c;

  assign id_class  = decode_class(opcode, func);
  // The IR holds the instruction, but the class is latched in ID so later states
  // do not depend on the IR staying stable.
  assign cur_class = (state_q == StId) ? id_class : class_q;

  assign in_wait = (state_q == StIf) || (state_q == StMem);
  assign timeout = in_wait && wait_expired && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_wait || mem_ready),
    .count   (in_wait && !mem_ready),
    .expired (wait_expired)
  );

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    imem_c    = 1'b0;
    ir_load_c = 1'b0;
    alu_c     = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    reg_wr_c  = 1'b0;
    illegal_c = 1'b0;

    unique case (state_q)
      StIf: begin
        imem_c = !timeout;
        if (mem_ready) begin
          ir_load_c = 1'b1;
          state_d   = StId;
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StId: begin
        case (cur_class)
          ClsJ:       retire = 1'b1;
          ClsIllegal: begin
            illegal_c = 1'b1;
            retire    = 1'b1;
          end
          ClsJal:     state_d = StWb;
          default:    state_d = StEx;
        endcase
      end
      StEx: begin
        alu_c = 1'b1;
        case (cur_class)
          ClsBranch, ClsJr: retire  = 1'b1;
          ClsLw, ClsSw:     state_d = StMem;
          default:          state_d = StWb;
        endcase
      end
      StMem: begin
        rd_c = (cur_class == ClsLw) && !timeout;
        wr_c = (cur_class == ClsSw) && !timeout;
        if (mem_ready) begin
          if (cur_class == ClsLw) begin
            state_d = StWb;
          end else begin
            retire = 1'b1;
          end
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StWb: begin
        reg_wr_c = 1'b1;
        retire   = 1'b1;
      end
      StHalt: begin
        if (!halt_req && !bus_err_q) begin
          state_d = StIf;
        end
      end
      default: state_d = StIf;
    endcase

    // halt_req only matters at an instruction boundary
    if (retire) begin
      state_d = halt_req ? StHalt : StIf;
    end
  end

  assign bus_err_d = bus_err_q | timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIf;
      class_q   <= ClsAlu;
      bus_err_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
      if (state_q == StId) begin
        class_q <= id_class;
      end
      if (retire) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // Strobes are gated by rst_n so nothing fires while reset is held.
  assign imem_req    = rst_n & imem_c;
  assign ir_load     = rst_n & ir_load_c;
  assign alu_en      = rst_n & alu_c;
  assign dmem_rd_req = rst_n & rd_c;
  assign dmem_wr_req = rst_n & wr_c;
  assign reg_wr_en   = rst_n & reg_wr_c;
  assign pc_en       = rst_n & retire;
  assign illegal     = rst_n & illegal_c;

  assign state   = state_q;
  assign halted  = (state_q == StHalt);
  assign bus_err = bus_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-instruction expectations are
// queued at issue and checked by a monitor on every pc_en.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  func = 6'd0;
  logic        mem_ready;
  logic        halt_req = 1'b0;
  logic        imem_req, ir_load, alu_en, dmem_rd_req, dmem_wr_req, reg_wr_en, pc_en;
  logic [2:0]  state;
  logic        halted, bus_err, illegal;
  logic [31:0] retired;

  int if_wait = 0;
  int mem_wait = 0;
  int wcnt;
  int n_checks = 0;
  int n_fail = 0;
  int exp_retired = 0;

  typedef struct {
    string       name;
    logic [31:0] path;
    int          alu, rd, wr, rw, ill, ir;
    int          ret;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .TIMEOUT (Timeout)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .func        (func),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .imem_req    (imem_req),
    .ir_load     (ir_load),
    .alu_en      (alu_en),
    .dmem_rd_req (dmem_rd_req),
    .dmem_wr_req (dmem_wr_req),
    .reg_wr_en   (reg_wr_en),
    .pc_en       (pc_en),
    .state       (state),
    .halted      (halted),
    .bus_err     (bus_err),
    .illegal     (illegal),
    .retired     (retired)
  );

  // Memory model: answers after a configured number of wait cycles in IF or MEM.
  logic in_mem;
  assign in_mem    = rst_n && (state == 3'd0 || state == 3'd3);
  assign mem_ready = in_mem && (wcnt >= ((state == 3'd0) ? if_wait : mem_wait));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (in_mem && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: accumulates per-instruction activity, compares on each retire.
  logic        in_instr = 1'b0;
  logic [31:0] path;
  int          c_alu, c_rd, c_wr, c_rw, c_ill, c_ir;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      in_instr = 1'b0;
    end else begin
      if (!in_instr && state == 3'd0) begin
        in_instr = 1'b1;
        path = 32'd0;
        c_alu = 0; c_rd = 0; c_wr = 0; c_rw = 0; c_ill = 0; c_ir = 0;
      end
      if (in_instr) begin
        path  = {path[27:0], {1'b0, state} + 4'd1};
        c_alu += int'(alu_en);
        c_rd  += int'(dmem_rd_req);
        c_wr  += int'(dmem_wr_req);
        c_rw  += int'(reg_wr_en);
        c_ill += int'(illegal);
        c_ir  += int'(ir_load);
      end
      if (pc_en) begin
        in_instr = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: pc_en seen, no instruction expected");
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_path"}, path, e.path);
          check({e.name, "_alu_en"}, c_alu, e.alu);
          check({e.name, "_dmem_rd"}, c_rd, e.rd);
          check({e.name, "_dmem_wr"}, c_wr, e.wr);
          check({e.name, "_reg_wr"}, c_rw, e.rw);
          check({e.name, "_illegal"}, c_ill, e.ill);
          check({e.name, "_ir_load"}, c_ir, e.ir);
          check({e.name, "_retired"}, retired, e.ret);
        end
      end
    end
  end

  // Path nibbles are state+1 per cycle: IF=1 ID=2 EX=3 MEM=4 WB=5.
  task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input int ifw, input int memw, input logic [31:0] p,
                       input int alu, input int rd, input int wr, input int rw,
                       input int ill, input bit halt_in_ex);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(posedge clk);
    #1;
    opcode = op; func = fn; if_wait = ifw; mem_wait = memw;
    e.name = name; e.path = p; e.alu = alu; e.rd = rd; e.wr = wr; e.rw = rw;
    e.ill = ill; e.ir = 1; e.ret = exp_retired;
    exp_q.push_back(e);
    exp_retired++;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (halt_in_ex && state == 3'd2) halt_req = 1'b1;
      if (pc_en) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_retire_wait: got no pc_en, expected one within 100 cycles", name);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected end within 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #12;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_state", state, 3'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_halted", halted, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("first_imem_req", imem_req, 1'b1);

    issue("add",   6'b000000, 6'b100000, 0, 0, 32'h1235,     1, 0, 0, 1, 0, 1'b0);
    issue("lw",    6'b100011, 6'd0,      0, 3, 32'h12344445, 1, 4, 0, 1, 0, 1'b0);
    issue("sw",    6'b101011, 6'd0,      0, 0, 32'h1234,     1, 0, 1, 0, 0, 1'b0);
    issue("addi",  6'b001000, 6'd0,      2, 0, 32'h111235,   1, 0, 0, 1, 0, 1'b0);
    issue("beq",   6'b000100, 6'd0,      0, 0, 32'h123,      1, 0, 0, 0, 0, 1'b0);
    // Ready arrives in the same cycle the wait count hits TIMEOUT: success.
    issue("bne",   6'b000101, 6'd0,      4, 0, 32'h1111123,  1, 0, 0, 0, 0, 1'b0);
    issue("jr",    6'b000000, 6'b001000, 0, 0, 32'h123,      1, 0, 0, 0, 0, 1'b0);
    issue("j",     6'b000010, 6'd0,      0, 0, 32'h12,       0, 0, 0, 0, 0, 1'b0);
    issue("jal",   6'b000011, 6'd0,      0, 0, 32'h125,      0, 0, 0, 1, 0, 1'b0);
    issue("undef", 6'b111111, 6'd0,      0, 0, 32'h12,       0, 0, 0, 0, 1, 1'b0);
    issue("beq_h", 6'b000100, 6'd0,      0, 0, 32'h123,      1, 0, 0, 0, 0, 1'b1);

    @(posedge clk); #1;
    check("halt_state", state, 3'd5);
    check("halt_halted", halted, 1'b1);
    check("halt_imem_req", imem_req, 1'b0);
    check("halt_retired", retired, exp_retired);
    repeat (2) @(posedge clk);
    #1;
    check("halt_hold", state, 3'd5);
    halt_req = 1'b0;
    @(posedge clk); #1;
    check("halt_release", state, 3'd0);

    // sw aborted by reset while stalled in MEM
    opcode = 6'b101011; func = 6'd0; if_wait = 0; mem_wait = 3;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (state == 3'd3) seen = 1'b1;
    end
    check("sw_reached_mem", seen, 1'b1);
    check("sw_wr_req", dmem_wr_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_wr_req", dmem_wr_req, 1'b0);
    check("abort_imem_req", imem_req, 1'b0);
    check("abort_pc_en", pc_en, 1'b0);
    check("abort_state", state, 3'd0);
    check("abort_retired", retired, 32'd0);
    exp_retired = 0;
    repeat (2) @(negedge clk);
    opcode = 6'b000000; func = 6'b100000; if_wait = 0; mem_wait = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("restart_imem_req", imem_req, 1'b1);
    issue("add2", 6'b000000, 6'b100000, 0, 0, 32'h1235, 1, 0, 0, 1, 0, 1'b0);

    // Fetch never answered: bus error after Timeout wait cycles.
    if_wait = 200;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("to_waiting_imem", imem_req, 1'b1);
    check("to_waiting_err", bus_err, 1'b0);
    @(posedge clk); #1;
    check("to_expire_state", state, 3'd0);
    check("to_expire_imem", imem_req, 1'b0);
    check("to_expire_pc_en", pc_en, 1'b0);
    @(posedge clk); #1;
    check("to_halt_state", state, 3'd5);
    check("to_bus_err", bus_err, 1'b1);
    check("to_halted", halted, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("to_halt_sticky", state, 3'd5);
    check("to_err_sticky", bus_err, 1'b1);
    check("to_retired", retired, 32'd1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
